// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock through a registered
// carry, with a start/busy/done handshake and signed-overflow detection.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_badParams
        $error("seq_adder: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] bShift_q;
    logic [WIDTH-1:0] psum_q;
    logic             carry_q;
    logic             aMsb_q;
    logic             bMsb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT:0]       digitAdd_d;
    logic [WIDTH+DIGIT-1:0] psumWide;
    logic [WIDTH-1:0]     psum_d;
    logic [WIDTH-1:0]     aShift_d;
    logic [WIDTH-1:0]     bShift_d;

    // New digits enter at the top of the partial sum, so after N shifts the LSB digit lands at bit 0.
    always_comb begin
        digitAdd_d = {1'b0, aShift_q[DIGIT-1:0]} + {1'b0, bShift_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
        psumWide   = {digitAdd_d[DIGIT-1:0], psum_q};
        psum_d     = psumWide[WIDTH+DIGIT-1:DIGIT];
        aShift_d   = aShift_q >> DIGIT;
        bShift_d   = bShift_q >> DIGIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            psum_q   <= '0;
            carry_q  <= 1'b0;
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        aShift_q <= a_i;
                        bShift_q <= b_i ^ {WIDTH{sub_i}};
                        carry_q  <= c_i ^ sub_i;
                        aMsb_q   <= a_i[WIDTH-1];
                        bMsb_q   <= b_i[WIDTH-1] ^ sub_i;
                        cnt_q    <= '0;
                        psum_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    aShift_q <= aShift_d;
                    bShift_q <= bShift_d;
                    psum_q   <= psum_d;
                    carry_q  <= digitAdd_d[DIGIT];
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= psum_d;
                        cout_q  <= digitAdd_d[DIGIT];
                        ovf_q   <= (aMsb_q == bMsb_q) && (psum_d[WIDTH-1] != aMsb_q);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule
